// File: rtl/mulu.sv
// rtl/mulu.sv - unsigned fixed-point shift-add multiplier, one product bit per clock
// Same start/busy/done/valid handshake as the unsigned fixed-point divider; truncating result.
module mulu #(
    parameter int WIDTH = 8,
    parameter int FBITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             ovf,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] val
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] mplr;
    logic [WIDTH:0]   acc;
    logic [IW-1:0]    i;

    logic [WIDTH:0]           sum;
    logic [WIDTH:0]           acc_next;
    logic [WIDTH-1:0]         mplr_next;
    logic [2*WIDTH-FBITS-1:0] prod_hi;
    logic                     last;
    logic                     ovf_next;

    // Product bits below FBITS are truncated, so only the upper part is kept.
    always_comb begin
        sum       = acc + (mplr[0] ? {1'b0, a1} : '0);
        acc_next  = {1'b0, sum[WIDTH:1]};
        mplr_next = {sum[0], mplr[WIDTH-1:1]};
        prod_hi   = {acc_next[WIDTH-1:0], mplr_next[WIDTH-1:FBITS]};
        ovf_next  = |prod_hi[2*WIDTH-FBITS-1:WIDTH];
        last      = (state == RUN) && (i == IW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (start) begin
            a1   <= a;
            mplr <= b;
            acc  <= '0;
            i    <= '0;
        end else if (state == RUN) begin
            acc  <= acc_next;
            mplr <= mplr_next;
            i    <= i + IW'(1);
        end
    end

    // A start in any state restarts; it also pre-empts the final iteration's done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            valid <= 1'b0;
            ovf   <= 1'b0;
            val   <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state <= RUN;
                busy  <= 1'b1;
                valid <= 1'b0;
                ovf   <= 1'b0;
            end else if (last) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
                if (ovf_next) begin
                    val <= '0;
                    ovf <= 1'b1;
                end else begin
                    val   <= prod_hi[WIDTH-1:0];
                    valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mulu.sv
// tb/tb_mulu.sv - self-checking bench for mulu (Q4.4 and a Q8.0 build)
module tb_mulu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         start0 = 1'b0;
    logic [W-1:0] a = '0, b = '0, a0 = '0, b0 = '0;
    logic         busy, done, valid, ovf;
    logic         busy0, done0, valid0, ovf0;
    logic [W-1:0] val, val0;

    int n_cmp = 0;
    int n_bad = 0;

    mulu #(.WIDTH(W), .FBITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .valid(valid), .ovf(ovf), .a(a), .b(b), .val(val)
    );

    mulu #(.WIDTH(W), .FBITS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
        .valid(valid0), .ovf(ovf0), .a(a0), .b(b0), .val(val0)
    );

    always #5 clk = ~clk;

    // Reference: exact product, shifted down by the fractional bits, must fit in W bits.
    function automatic void ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input int fb,
                                    output logic [W-1:0] v, output logic vl, output logic o);
        longint p;
        p = (longint'(x) * longint'(y)) >>> fb;
        if (p >= (longint'(1) << W)) begin
            v = '0; vl = 1'b0; o = 1'b1;
        end else begin
            v = W'(p); vl = 1'b1; o = 1'b0;
        end
    endfunction

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit full,
                          output int lat, output int nd, output int bc);
        lat = -1; nd = 0; bc = 0;
        @(negedge clk); a = x; b = y; start = 1'b1;
        @(negedge clk); start = 1'b0; a = W'($urandom); b = W'($urandom);
        if (busy) bc++;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                nd++;
                if (lat < 0) lat = k;
            end
            if (!full && nd > 0) break;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, valid, ovf, val} !== {4'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b valid=%b ovf=%b val=%h, want all 0",
                     busy, done, valid, ovf, val);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [W-1:0] tx[6] = '{8'h18, 8'h11, 8'h03, 8'hFF, 8'h40, 8'h00};
        logic [W-1:0] ty[6] = '{8'h28, 8'h11, 8'h03, 8'h10, 8'h40, 8'hFF};
        logic [W-1:0] tv[6] = '{8'h3C, 8'h12, 8'h00, 8'hFF, 8'h00, 8'h00};
        logic         tvl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic         to[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int lat, nd, bc;
        for (int t = 0; t < 6; t++) begin
            run_op(tx[t], ty[t], 1'b1, lat, nd, bc);
            n_cmp++;
            if (lat !== W || nd !== 1 || bc !== W) begin
                n_bad++;
                $display("FAIL vec%0d_timing: got latency=%0d dones=%0d busy_cycles=%0d, want %0d/1/%0d",
                         t, lat, nd, bc, W, W);
            end
            n_cmp++;
            if (val !== tv[t] || valid !== tvl[t] || ovf !== to[t]) begin
                n_bad++;
                $display("FAIL vec%0d_result: a=%h b=%h got val=%h valid=%b ovf=%b, want %h/%b/%b",
                         t, tx[t], ty[t], val, valid, ovf, tv[t], tvl[t], to[t]);
            end
        end
    endtask

    task automatic test_hold();
        int lat, nd, bc;
        run_op(8'h18, 8'h28, 1'b1, lat, nd, bc);
        @(negedge clk); a = 8'h40; b = 8'h40; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_cmp++;
        if (val !== 8'h3C || valid !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_clears_valid: got val=%h valid=%b busy=%b, want 3c/0/1", val, valid, busy);
        end
        repeat (W + 4) @(negedge clk);
        n_cmp++;
        if (val !== 8'h00 || valid !== 1'b0 || ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_hold: got val=%h valid=%b ovf=%b, want 00/0/1", val, valid, ovf);
        end
    endtask

    task automatic test_fbits0();
        logic [W-1:0] tx[2] = '{8'h0F, 8'h10};
        logic [W-1:0] ty[2] = '{8'h11, 8'h10};
        logic [W-1:0] ev;
        logic         evl, eo;
        for (int t = 0; t < 2; t++) begin
            ref_mul(tx[t], ty[t], 0, ev, evl, eo);
            @(negedge clk); a0 = tx[t]; b0 = ty[t]; start0 = 1'b1;
            @(negedge clk); start0 = 1'b0;
            repeat (W) @(negedge clk);
            n_cmp++;
            if (done0 !== 1'b1 || val0 !== ev || valid0 !== evl || ovf0 !== eo) begin
                n_bad++;
                $display("FAIL fbits0_%0d: got done=%b val=%h valid=%b ovf=%b, want 1/%h/%b/%b",
                         t, done0, val0, valid0, ovf0, ev, evl, eo);
            end
        end
    endtask

    task automatic test_restart();
        int lat, nd, nd_old, bc;
        nd_old = 0;
        @(negedge clk); a = 8'h18; b = 8'h28; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) nd_old++;
        end
        run_op(8'h20, 8'h20, 1'b1, lat, nd, bc);
        n_cmp++;
        if (nd_old + nd !== 1 || lat !== W || val !== 8'h40 || valid !== 1'b1) begin
            n_bad++;
            $display("FAIL restart: got dones=%0d latency=%0d val=%h valid=%b, want 1/%0d/40/1",
                     nd_old + nd, lat, val, valid, W);
        end
        nd_old = 0;
        @(negedge clk); a = 8'h18; b = 8'h28; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= W - 2; k++) begin
            @(negedge clk);
            if (done) nd_old++;
        end
        run_op(8'h40, 8'h20, 1'b1, lat, nd, bc);
        n_cmp++;
        if (nd_old + nd !== 1 || lat !== W || val !== 8'h80 || valid !== 1'b1) begin
            n_bad++;
            $display("FAIL start_on_done_edge: got dones=%0d latency=%0d val=%h valid=%b, want 1/%0d/80/1",
                     nd_old + nd, lat, val, valid, W);
        end
    endtask

    task automatic test_async_reset();
        int lat, nd, bc;
        run_op(8'h18, 8'h28, 1'b1, lat, nd, bc);
        @(negedge clk); a = 8'h11; b = 8'h11; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || valid !== 1'b0 || ovf !== 1'b0 || val !== 8'h00) begin
            n_bad++;
            $display("FAIL async_reset: got busy=%b valid=%b ovf=%b val=%h before edge, want 0/0/0/00",
                     busy, valid, ovf, val);
        end
        @(negedge clk); rst_n = 1'b1;
        nd = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (done) nd++;
        end
        n_cmp++;
        if (nd !== 0) begin
            n_bad++;
            $display("FAIL no_done_after_reset: got dones=%0d, want 0", nd);
        end
        run_op(8'h20, 8'h20, 1'b1, lat, nd, bc);
        n_cmp++;
        if (nd !== 1 || lat !== W || val !== 8'h40 || valid !== 1'b1) begin
            n_bad++;
            $display("FAIL after_reset_op: got dones=%0d latency=%0d val=%h valid=%b, want 1/%0d/40/1",
                     nd, lat, val, valid, W);
        end
    endtask

    task automatic test_random(input int n);
        logic [W-1:0] x, y, ev;
        logic         evl, eo;
        int lat, nd, bc;
        for (int t = 0; t < n; t++) begin
            x = W'($urandom);
            y = W'($urandom);
            if ($urandom_range(0, 7) == 0) x = '1;
            if ($urandom_range(0, 7) == 0) y = '0;
            ref_mul(x, y, 4, ev, evl, eo);
            run_op(x, y, 1'b0, lat, nd, bc);
            n_cmp++;
            if (lat !== W || val !== ev || valid !== evl || ovf !== eo) begin
                n_bad++;
                $display("FAIL random%0d: a=%h b=%h got latency=%0d val=%h valid=%b ovf=%b, want %0d/%h/%b/%b",
                         t, x, y, lat, val, valid, ovf, W, ev, evl, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_fbits0();
        test_restart();
        test_async_reset();
        test_random(4000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
